// File: rtl/opl2_pkg.sv
// Shared OPL2 register-bus types and timer constants.
package opl2_pkg;
  localparam int REG_TIMER_WIDTH     = 8;
  localparam int TIMER1_TICK_SAMPLES = 4;
  localparam int TIMER2_TICK_SAMPLES = 16;

  localparam logic [7:0] TIMER1_ADDR     = 8'h02;
  localparam logic [7:0] TIMER2_ADDR     = 8'h03;
  localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
  } opl2_reg_wr_t;
endpackage

// File: rtl/opl2_timer_counter.sv
// One OPL2 timer: free-running tick sub-divider plus an 8-bit preset up-counter.
module opl2_timer_counter
  import opl2_pkg::*;
#(
  parameter int TICK_SAMPLES = 4
) (
  input  logic                       clk,
  input  logic                       ic_n,
  input  logic                       sample_tick,
  input  logic                       start,
  input  logic [REG_TIMER_WIDTH-1:0] preset,
  output logic                       ovf
);
  localparam int SW = $clog2(TICK_SAMPLES);

  logic [SW-1:0]              sub_cnt;
  logic [REG_TIMER_WIDTH-1:0] cnt;
  logic                       start_q, tick, running;

  // start is the next-state ST bit, so a 0->1 write loads on its own edge.
  assign tick    = sample_tick && (sub_cnt == SW'(TICK_SAMPLES - 1));
  assign running = start && start_q;
  assign ovf     = running && tick && (cnt == '1);

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      sub_cnt <= '0;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      if (tick)             sub_cnt <= '0;
      else if (sample_tick) sub_cnt <= sub_cnt + 1'b1;
      if (start && !start_q) cnt <= preset;
      else if (running && tick) cnt <= (cnt == '1) ? preset : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/opl2_timers.sv
// OPL2 timer/status block: presets, control decode, prescaler, flags and IRQ.
module opl2_timers
  import opl2_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 72
) (
  input  logic         clk,
  input  logic         ic_n,
  input  opl2_reg_wr_t reg_wr,
  input  logic         force_timer_overflow,
  output logic [7:0]   status,
  output logic         irq_n
);
  localparam int PW         = $clog2(CLKS_PER_SAMPLE);
  localparam int NUM_TIMERS = 2;

  logic [PW-1:0]                                 presc;
  logic                                          sample_tick;
  logic [NUM_TIMERS-1:0][REG_TIMER_WIDTH-1:0]    t_val;
  logic [NUM_TIMERS-1:0]                         mask, st, st_nxt, ovf, ft, set_flag;
  logic                                          ctrl_wr, flag_rst, force_q, force_edge;

  assign sample_tick = (presc == PW'(CLKS_PER_SAMPLE - 1));
  assign ctrl_wr     = reg_wr.valid && (reg_wr.address == TIMER_CTRL_ADDR);
  assign flag_rst    = ctrl_wr && reg_wr.data[7];
  assign st_nxt      = (ctrl_wr && !reg_wr.data[7]) ? reg_wr.data[1:0] : st;
  assign force_edge  = force_timer_overflow && !force_q;
  // A forced edge behaves exactly like a Timer 1 overflow, gated by MASK1.
  assign set_flag    = (ovf | {1'b0, force_edge}) & ~mask;

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      presc   <= '0;
      t_val   <= '0;
      mask    <= '0;
      st      <= '0;
      ft      <= '0;
      force_q <= 1'b0;
    end else begin
      presc   <= sample_tick ? '0 : presc + 1'b1;
      st      <= st_nxt;
      force_q <= force_timer_overflow;
      // Set beats clear when both land on the same edge.
      ft      <= (ft & ~{NUM_TIMERS{flag_rst}}) | set_flag;
      if (reg_wr.valid && reg_wr.address == TIMER1_ADDR) t_val[0] <= reg_wr.data;
      if (reg_wr.valid && reg_wr.address == TIMER2_ADDR) t_val[1] <= reg_wr.data;
      if (ctrl_wr && !reg_wr.data[7]) mask <= {reg_wr.data[5], reg_wr.data[6]};
    end
  end

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
    opl2_timer_counter #(
      .TICK_SAMPLES ((i == 0) ? TIMER1_TICK_SAMPLES : TIMER2_TICK_SAMPLES)
    ) u_tmr (
      .clk         (clk),
      .ic_n        (ic_n),
      .sample_tick (sample_tick),
      .start       (st_nxt[i]),
      .preset      (t_val[i]),
      .ovf         (ovf[i])
    );
  end

  assign status = {|ft, ft[0], ft[1], 5'b0};
  assign irq_n  = ~|ft;
endmodule

// File: tb/tb_opl2_timers.sv
// Directed bench for opl2_timers with CLKS_PER_SAMPLE = 4 (t1 tick = 16 clk, t2 tick = 64 clk).
module tb_opl2_timers;
  import opl2_pkg::*;

  logic         clk = 1'b0;
  logic         ic_n = 1'b0;
  opl2_reg_wr_t reg_wr = '0;
  logic         force_timer_overflow = 1'b0;
  logic [7:0]   status;
  logic         irq_n;
  int           total = 0, bad = 0, cyc = 0;
  int           n, t0, t1, t2, nz;

  opl2_timers #(.CLKS_PER_SAMPLE(4)) dut (
    .clk                  (clk),
    .ic_n                 (ic_n),
    .reg_wr               (reg_wr),
    .force_timer_overflow (force_timer_overflow),
    .status               (status),
    .irq_n                (irq_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    reg_wr = '{valid: 1'b1, address: a, data: d};
    @(posedge clk); #1;
    reg_wr.valid = 1'b0;
  endtask

  // Steps clock edges until status matches or the bound runs out.
  task automatic wait_st(input logic [7:0] exp, input int max, output int cnt);
    cnt = 0;
    while (status !== exp && cnt < max) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic idle_nz(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (status !== 8'h00 || irq_n !== 1'b1) cnt++;
    end
  endtask

  initial begin
    // Reset state and idle
    #12;
    chk("rst_status", status, 8'h00);
    chk("rst_irq_n", irq_n, 1'b1);
    ic_n = 1'b1;
    idle_nz(2000, nz);
    chk("idle_2000", nz, 0);

    // Timer 1 preset FF: first overflow within one t1 tick, then every 16 cycles
    wr(TIMER1_ADDR, 8'hFF);
    wr(TIMER_CTRL_ADDR, 8'h01);
    wait_st(8'hC0, 40, n);
    chk("t1_first_st", status, 8'hC0);
    chk("t1_first_irq_n", irq_n, 1'b0);
    chk("t1_first_le17", (n >= 1 && n <= 17), 1'b1);
    t0 = cyc;
    wr(TIMER_CTRL_ADDR, 8'h80);
    chk("t1_rst_clr", status, 8'h00);
    wait_st(8'hC0, 40, n);
    t1 = cyc;
    chk("t1_period_a", t1 - t0, 16);
    wr(TIMER_CTRL_ADDR, 8'h80);
    wait_st(8'hC0, 40, n);
    t2 = cyc;
    chk("t1_period_b", t2 - t1, 16);
    wr(TIMER_CTRL_ADDR, 8'h00);
    wr(TIMER_CTRL_ADDR, 8'h80);
    chk("t1_stop_clr", status, 8'h00);

    // Preset 00 needs 256 ticks: 4081..4096 cycles after start
    wr(TIMER1_ADDR, 8'h00);
    wr(TIMER_CTRL_ADDR, 8'h01);
    wait_st(8'hC0, 5000, n);
    chk("t1_p00_st", status, 8'hC0);
    chk("t1_p00_range", (n >= 4081 && n <= 4096), 1'b1);
    wr(TIMER_CTRL_ADDR, 8'h00);
    wr(TIMER_CTRL_ADDR, 8'h80);

    // Timer 2 preset FE: two t2 ticks
    wr(TIMER2_ADDR, 8'hFE);
    wr(TIMER_CTRL_ADDR, 8'h02);
    wait_st(8'hA0, 200, n);
    chk("t2_st", status, 8'hA0);
    chk("t2_range", (n >= 65 && n <= 129), 1'b1);
    wr(TIMER_CTRL_ADDR, 8'h00);
    wr(TIMER_CTRL_ADDR, 8'h80);
    chk("t2_clr", status, 8'h00);

    // MASK1 suppresses FT1, unmask lets the running timer flag again
    wr(TIMER1_ADDR, 8'hFF);
    wr(TIMER_CTRL_ADDR, 8'h41);
    idle_nz(200, nz);
    chk("mask1_quiet", nz, 0);
    wr(TIMER_CTRL_ADDR, 8'h01);
    wait_st(8'hC0, 20, n);
    chk("unmask_st", status, 8'hC0);
    wr(TIMER_CTRL_ADDR, 8'h80);
    chk("unmask_rst", status, 8'h00);
    wr(TIMER_CTRL_ADDR, 8'h00);
    wr(TIMER_CTRL_ADDR, 8'h80);

    // Forced overflow with timers stopped
    @(posedge clk); #1;
    force_timer_overflow = 1'b1;
    @(posedge clk); #1;
    chk("force_st", status, 8'hC0);
    wr(TIMER_CTRL_ADDR, 8'h80);
    chk("force_held_clr", status, 8'h00);
    idle_nz(50, nz);
    chk("force_held_quiet", nz, 0);
    force_timer_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    force_timer_overflow = 1'b1;
    @(posedge clk); #1;
    chk("force_reraise", status, 8'hC0);
    force_timer_overflow = 1'b0;
    wr(TIMER_CTRL_ADDR, 8'h80);
    chk("force_clr2", status, 8'h00);

    // Forced edge on the same edge as RST: set wins
    @(posedge clk); #1;
    reg_wr = '{valid: 1'b1, address: TIMER_CTRL_ADDR, data: 8'h80};
    force_timer_overflow = 1'b1;
    @(posedge clk); #1;
    reg_wr.valid = 1'b0;
    chk("set_beats_clr", status, 8'hC0);
    force_timer_overflow = 1'b0;
    wr(TIMER_CTRL_ADDR, 8'h80);

    // Asynchronous reset mid-count, then no activity without a new start
    wr(TIMER1_ADDR, 8'hFE);
    wr(TIMER_CTRL_ADDR, 8'h01);
    wait_st(8'hC0, 60, n);
    chk("pre_reset_st", status, 8'hC0);
    #3 ic_n = 1'b0;
    #1;
    chk("async_rst_st", status, 8'h00);
    chk("async_rst_irq_n", irq_n, 1'b1);
    #2 ic_n = 1'b1;
    idle_nz(500, nz);
    chk("post_reset_quiet", nz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/opl2_timers.md
# opl2_timers

OPL2 timer/status block: holds the Timer 1 and Timer 2 preset registers, runs both 8-bit up-counters from a free-running sample-rate prescaler, and produces the status byte and active-low IRQ.
- Sits in the `clk` domain, downstream of the register-write decoder and of the software-detection helper.
- Consumes that helper's synchronized `force_timer_overflow`, so a forced Timer 1 overflow appears in status exactly as a real one does.

## Interface
- `CLKS_PER_SAMPLE`, default 72: `clk` cycles per OPL sample tick (3.579545 MHz / 72 ≈ 49.7 kHz). Must be ≥ 2.
- `clk`  in  1  OPL clock; the only clock.
- `ic_n`  in  1  reset, asynchronous and active-low.
- `reg_wr`  in  `opl2_reg_wr_t`  register write bus (`valid`, `address[7:0]`, `data[7:0]`), one-cycle `valid` pulses.
- `force_timer_overflow`  in  1  level, already synchronized to `clk`; its rising edge acts as a Timer 1 overflow.
- `status`  out  8  {IRQ, FT1, FT2, 5'b0}.
- `irq_n`  out  1  low while IRQ = 1.

## Operation
Registers are written only when `reg_wr.valid` = 1:
- 0x02: Timer 1 preset `t1_val[7:0]`.
- 0x03: Timer 2 preset `t2_val[7:0]`.
- 0x04 with data[7] = 1 (RST): clears FT1 and FT2. All other bits of that write are ignored.
- 0x04 with data[7] = 0: stores MASK1 = d[6], MASK2 = d[5], ST2 = d[1], ST1 = d[0].
- Other addresses: ignored.

Prescaler and ticks:
- Free-running modulo-`CLKS_PER_SAMPLE` prescaler produces `sample_tick`.
- A 2-bit sub-counter gives `t1_tick` every 4 sample ticks (80.5 µs); a 4-bit sub-counter gives `t2_tick` every 16 (321.8 µs).
- None of these counters are reset by ST writes, so the first tick after a start lands 1..interval samples later.

Per timer n:
- ST n 0→1: counter is loaded with `tn_val`.
- While ST n = 1, each `tn_tick` increments the counter.
- On a tick with counter = 0xFF: counter reloads `tn_val` and `ovf_n` pulses for one cycle.
- ST n = 0: counter holds its value; no ticks, no overflow.
- Writing `tn_val` while running takes effect at the next reload or start only.

Flags:
- FT1 is set on `ovf_1` or on a rising edge of `force_timer_overflow` (edge detector registered in this block), only if MASK1 = 0.
- FT2 is set on `ovf_2`, only if MASK2 = 0.
- Setting a mask does not clear an already-set flag.
- IRQ = FT1 | FT2. `irq_n` = !IRQ.
- A forced overflow does not touch the Timer 1 counter.

## Timing
- Reset values:
  - `status` = 0x00, `irq_n` = 1.
  - Presets = 0, masks = 0, ST = 0, counters = 0.
  - Prescaler and sub-counters = 0; edge-detector history = 0.
- Write latency: register state updates on the clock edge that samples `valid`. ST 0→1 loads the counter on that same edge; a tick coinciding with the start write is ignored.
- Overflow latency: a tick at 0xFF sets the flag on the following edge, so `status` and `irq_n` change 1 cycle after the overflowing tick.
- Forced overflow: FT1 is set 1 cycle after the `force_timer_overflow` rising edge is seen. A held level does not re-trigger after an RST.
- Set beats clear: RST in the same cycle as `ovf_n` or a forced edge leaves the flag set.
- Preset 0xFF overflows on every tick; preset 0x00 takes 256 ticks.
- Reset asserted mid-count returns everything to reset values immediately (asynchronously). Counting resumes only after a new ST write.

## Structure
- `opl2_pkg` holds:
  - `REG_TIMER_WIDTH` (8) and the existing `opl2_reg_wr_t`.
  - New constants `TIMER1_TICK_SAMPLES` = 4, `TIMER2_TICK_SAMPLES` = 16.
  - New address constants `TIMER1_ADDR` = 'h2, `TIMER2_ADDR` = 'h3, `TIMER_CTRL_ADDR` = 'h4.
- One sub-module, `opl2_timer_counter`, instanced twice:
  - parameter `TICK_SAMPLES`;
  - inputs `clk`, `ic_n`, `sample_tick`, `start`, `preset`;
  - output `ovf` pulse;
  - contains its own sub-counter, load-on-start edge logic and 8-bit counter.
- Top level keeps the prescaler, register decode, mask/flag logic and force-edge detector.

## Test plan
(All scenarios use `CLKS_PER_SAMPLE` = 4.)
- Reset release → `status` = 0x00, `irq_n` = 1; no flag change after 2000 cycles with ST = 0.
- t1_val = 0xFF, write 0x04 = 0x01 → `status` = 0xC0 within 4 samples (≤ 17 cycles) of the start; every subsequent FT1 set event occurs exactly 16 cycles apart (verify via RST between).
- t2_val = 0xFE, write 0x04 = 0x02 (MASK1 = 0, ST2) → `status` = 0xA0 after 2 t2 ticks (between 65 and 129 cycles after the start).
- MASK1 = 1, ST1 = 1, t1_val = 0xFF → `status` stays 0x00 over 200 cycles. Then write 0x04 = 0x01 → 0xC0. Then write 0x04 = 0x80 → 0x00 next cycle.
- Raise `force_timer_overflow` with ST1 = 0 → `status` = 0xC0 one cycle later. Hold it high, write RST → 0x00 and stays 0x00. Lower and re-raise → 0xC0.
- Timer 1 running at 0xFE, assert `ic_n` = 0 mid-count → `status` = 0x00, `irq_n` = 1 immediately. After release with no writes, no flag over 500 cycles.
